// File: rtl/ball_controller_if.sv
// Brick-detector bus between the ball controller and the brick memory/detector.
//   brick_addr            : brick memory read address (1-cycle read latency)
//   enable_brick_detector : arms the detector for the word currently on its input
//   brick_collision       : registered detector result (01 vert, 10 horiz, 11 diag, 00 none)
//   brick_hit             : one-cycle clear request for the first brick hit in a frame
//   brick_hit_addr        : address of that brick
interface ball_controller_if;
  logic [4:0] brick_addr;
  logic       enable_brick_detector;
  logic [1:0] brick_collision;
  logic       brick_hit;
  logic [4:0] brick_hit_addr;

  modport master (
    output brick_addr,
    output enable_brick_detector,
    output brick_hit,
    output brick_hit_addr,
    input  brick_collision
  );

  modport slave (
    input  brick_addr,
    input  enable_brick_detector,
    input  brick_hit,
    input  brick_hit_addr,
    output brick_collision
  );
endinterface

// File: rtl/ball_controller.sv
// Ball controller: per frame, scans all bricks through the detector, resolves brick,
// paddle and wall bounces, then moves the 3x3 ball by one pixel in each axis.
// Optional feature macro: BRICK_HIT_CLEAR_EN (enables brick_hit / brick_hit_addr).
// Ports:
//   clock, reset           : system clock, synchronous active-high reset
//   frame_tick             : one-cycle pulse per frame, starts a motion step
//   launch                 : releases the ball from the paddle while serving
//   paddle_x, paddle_y     : paddle top-left corner
//   paddle_collision       : combinational paddle-hit flag
//   brick                  : brick-detector bus (master side)
//   ball_x, ball_y         : ball top-left corner
//   h/v_ball_direction     : 1 = right/down, 0 = left/up
//   ball_lost              : one-cycle pulse when the ball leaves the bottom edge
//   busy                   : high while a frame step is in progress
module ball_controller #(
  parameter int unsigned NUM_BRICKS = 20,
  parameter int unsigned SCREEN_W   = 160,
  parameter int unsigned SCREEN_H   = 120
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              frame_tick,
  input  logic              launch,
  input  logic [7:0]        paddle_x,
  input  logic [6:0]        paddle_y,
  input  logic              paddle_collision,
  ball_controller_if.master brick,
  output logic [7:0]        ball_x,
  output logic [6:0]        ball_y,
  output logic              h_ball_direction,
  output logic              v_ball_direction,
  output logic              ball_lost,
  output logic              busy
);

  typedef enum logic [2:0] {StServe, StWait, StScan, StDrain, StResolve, StMove} state_e;

  localparam logic [4:0] LastAddr = 5'(NUM_BRICKS - 1);

  state_e     state_q, state_d;
  logic [4:0] addr_q;
  logic       en_q;
  logic [4:0] en_addr_q;
  logic       samp_q;
  logic [4:0] samp_addr_q;
  logic       drain_q;
  logic       hit_q;
  logic [1:0] hit_code_q;
  logic [4:0] hit_addr_q;
  logic [7:0] x_q;
  logic [6:0] y_q;
  logic       h_q, v_q;
  logic       h_res, v_res, lost_res;
  logic [7:0] serve_x;
  logic [6:0] serve_y;

  assign serve_x = paddle_x + 8'd8;
  assign serve_y = paddle_y - 7'd3;

  // Bounce resolution, in priority order: brick, paddle, walls; loss uses the final v.
  always_comb begin
    h_res = h_q ^ hit_code_q[1];
    v_res = v_q ^ hit_code_q[0];
    if (paddle_collision && v_res) v_res = 1'b0;
    if (x_q == 8'd0 && !h_res) h_res = 1'b1;
    if (({1'b0, x_q} + 9'd2) == 9'(SCREEN_W - 1) && h_res) h_res = 1'b0;
    if (y_q == 7'd0 && !v_res) v_res = 1'b1;
    lost_res = (({1'b0, y_q} + 8'd2) >= 8'(SCREEN_H - 1)) && v_res;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StServe:   if (launch && frame_tick) state_d = StWait;
      StWait:    if (frame_tick) state_d = StScan;
      StScan:    if (addr_q == LastAddr) state_d = StDrain;
      StDrain:   if (drain_q) state_d = StResolve;
      StResolve: state_d = lost_res ? StServe : StMove;
      StMove:    state_d = StWait;
      default:   state_d = StServe;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StServe;
      addr_q      <= 5'd0;
      en_q        <= 1'b0;
      en_addr_q   <= 5'd0;
      samp_q      <= 1'b0;
      samp_addr_q <= 5'd0;
      drain_q     <= 1'b0;
      hit_q       <= 1'b0;
      hit_code_q  <= 2'b00;
      hit_addr_q  <= 5'd0;
      x_q         <= serve_x;
      y_q         <= serve_y;
      h_q         <= 1'b1;
      v_q         <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= (state_q == StScan && addr_q != LastAddr) ? addr_q + 5'd1 : 5'd0;
      // Address -> memory (1 cycle) -> registered detector (1 cycle): the result for an
      // address is valid two cycles after it was driven.
      en_q        <= (state_q == StScan);
      en_addr_q   <= addr_q;
      samp_q      <= en_q;
      samp_addr_q <= en_addr_q;
      drain_q     <= (state_q == StDrain) && !drain_q;

      if (state_q == StWait && frame_tick) begin
        hit_q      <= 1'b0;
        hit_code_q <= 2'b00;
        hit_addr_q <= 5'd0;
      end else if (samp_q && !hit_q && brick.brick_collision != 2'b00) begin
        hit_q      <= 1'b1;
        hit_code_q <= brick.brick_collision;
        hit_addr_q <= samp_addr_q;
      end

      case (state_q)
        StServe: begin
          x_q <= serve_x;
          y_q <= serve_y;
          h_q <= 1'b1;
          v_q <= 1'b0;
        end
        StResolve: begin
          h_q <= h_res;
          v_q <= v_res;
        end
        StMove: begin
          x_q <= h_q ? x_q + 8'd1 : x_q - 8'd1;
          y_q <= v_q ? y_q + 7'd1 : y_q - 7'd1;
        end
        default: ;
      endcase
    end
  end

  // While serving the ball rides on the paddle combinationally.
  assign ball_x           = (state_q == StServe) ? serve_x : x_q;
  assign ball_y           = (state_q == StServe) ? serve_y : y_q;
  assign h_ball_direction = (state_q == StServe) ? 1'b1 : h_q;
  assign v_ball_direction = (state_q == StServe) ? 1'b0 : v_q;

  assign busy      = !(state_q == StServe || state_q == StWait);
  assign ball_lost = (state_q == StResolve) && lost_res;

  assign brick.brick_addr            = addr_q;
  assign brick.enable_brick_detector = en_q;

`ifdef BRICK_HIT_CLEAR_EN
  assign brick.brick_hit      = (state_q == StResolve) && hit_q;
  assign brick.brick_hit_addr = ((state_q == StResolve) && hit_q) ? hit_addr_q : 5'd0;
`else
  assign brick.brick_hit      = 1'b0;
  assign brick.brick_hit_addr = 5'd0;
`endif

endmodule

// File: tb/tb_ball_controller.sv
module tb_ball_controller;
  localparam int N = 20;
  localparam int W = 160;
  localparam int H = 120;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       launch = 1'b0;
  logic       paddle_collision = 1'b0;
  logic [7:0] paddle_x = 8'd70;
  logic [6:0] paddle_y = 7'd60;
  logic [7:0] ball_x;
  logic [6:0] ball_y;
  logic       h_dir, v_dir, ball_lost, busy;

  ball_controller_if bus ();

  ball_controller #(.NUM_BRICKS(N), .SCREEN_W(W), .SCREEN_H(H)) dut (
    .clock            (clock),
    .reset            (reset),
    .frame_tick       (frame_tick),
    .launch           (launch),
    .paddle_x         (paddle_x),
    .paddle_y         (paddle_y),
    .paddle_collision (paddle_collision),
    .brick            (bus),
    .ball_x           (ball_x),
    .ball_y           (ball_y),
    .h_ball_direction (h_dir),
    .v_ball_direction (v_dir),
    .ball_lost        (ball_lost),
    .busy             (busy)
  );

  always #5 clock = ~clock;

  // Brick memory (1-cycle read) followed by a registered detector that outputs 00 when idle.
  logic [1:0] mem_codes [32];
  logic [1:0] mem_q;
  always @(posedge clock) begin
    mem_q               <= mem_codes[bus.brick_addr];
    bus.brick_collision <= bus.enable_brick_detector ? mem_q : 2'b00;
  end

  int vectors = 0;
  int miscompares = 0;

  // Frame-level reference state of the ball.
  int m_x, m_y;
  bit m_h, m_v;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_codes();
    for (int i = 0; i < 32; i++) mem_codes[i] = 2'b00;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    frame_tick = 1'b0;
    launch = 1'b0;
    paddle_collision = 1'b0;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    #1;
    chk("rst_addr", 32'(bus.brick_addr), 0);
    chk("rst_en", 32'(bus.enable_brick_detector), 0);
    chk("rst_lost", 32'(ball_lost), 0);
    chk("rst_hit", 32'(bus.brick_hit), 0);
    chk("rst_hit_addr", 32'(bus.brick_hit_addr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_h", 32'(h_dir), 1);
    chk("rst_v", 32'(v_dir), 0);
    chk("rst_x", 32'(ball_x), 32'(paddle_x) + 8);
    chk("rst_y", 32'(ball_y), 32'(paddle_y) - 3);
  endtask

  // From SERVE: place the paddle, launch, and land in WAIT.
  task automatic launch_ball(input int px, input int py);
    paddle_x = 8'(px);
    paddle_y = 7'(py);
    launch = 1'b1;
    frame_tick = 1'b1;
    #1;
    chk("serve_x", 32'(ball_x), px + 8);
    chk("serve_y", 32'(ball_y), py - 3);
    chk("serve_h", 32'(h_dir), 1);
    next_cycle();
    launch = 1'b0;
    frame_tick = 1'b0;
    #1;
    chk("wait_busy", 32'(busy), 0);
    chk("wait_x", 32'(ball_x), px + 8);
    m_x = px + 8;
    m_y = py - 3;
    m_h = 1'b1;
    m_v = 1'b0;
  endtask

  // One frame starting from WAIT; checks the scan/drain/resolve timeline.
  task automatic run_frame(input int pre_x, input int pre_y, input bit pc, input bit exp_lost,
                           input bit exp_hv, input int exp_ha, input bit noise);
    paddle_collision = pc;
    frame_tick = 1'b1;
    next_cycle();
    for (int s = 0; s < N; s++) begin
      frame_tick = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      launch = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      chk("scan_addr", 32'(bus.brick_addr), s);
      chk("scan_en", 32'(bus.enable_brick_detector), (s > 0) ? 1 : 0);
      chk("scan_busy", 32'(busy), 1);
      if (s == 0 || s == N - 1) begin
        chk("scan_hold_x", 32'(ball_x), pre_x);
        chk("scan_hold_y", 32'(ball_y), pre_y);
      end
      next_cycle();
    end
    #1;
    chk("drain1_en", 32'(bus.enable_brick_detector), 1);
    chk("drain1_busy", 32'(busy), 1);
    next_cycle();
    #1;
    chk("drain2_en", 32'(bus.enable_brick_detector), 0);
    chk("drain2_busy", 32'(busy), 1);
    next_cycle();
    frame_tick = 1'b0;
    launch = 1'b0;
    #1;
    chk("resolve_lost", 32'(ball_lost), 32'(exp_lost));
    chk("resolve_hit", 32'(bus.brick_hit), 32'(exp_hv));
    chk("resolve_hit_addr", 32'(bus.brick_hit_addr), exp_hv ? exp_ha : 0);
    chk("resolve_busy", 32'(busy), 1);
    next_cycle();
    #1;
    chk("post_lost", 32'(ball_lost), 0);
    chk("post_hit", 32'(bus.brick_hit), 0);
    if (exp_lost) begin
      chk("lost_serve_busy", 32'(busy), 0);
    end else begin
      chk("move_busy", 32'(busy), 1);
      next_cycle();
      #1;
      chk("wait_busy", 32'(busy), 0);
    end
  endtask

  task automatic model_frame(input bit pc, output bit lost, output bit hv, output int ha);
    int first;
    bit h, v;
    first = -1;
    for (int a = 0; a < N; a++) if (first < 0 && mem_codes[a] != 2'b00) first = a;
    h = m_h;
    v = m_v;
    if (first >= 0) begin
      if (mem_codes[first][0]) v = !v;
      if (mem_codes[first][1]) h = !h;
    end
    if (pc && v) v = 1'b0;
    if (m_x == 0 && !h) h = 1'b1;
    if (m_x + 2 == W - 1 && h) h = 1'b0;
    if (m_y == 0 && !v) v = 1'b1;
    lost = (m_y + 2 >= H - 1) && v;
`ifdef BRICK_HIT_CLEAR_EN
    hv = (first >= 0);
    ha = (first >= 0) ? first : 0;
`else
    hv = 1'b0;
    ha = 0;
`endif
    if (!lost) begin
      m_x = h ? m_x + 1 : m_x - 1;
      m_y = v ? m_y + 1 : m_y - 1;
      m_h = h;
      m_v = v;
    end
  endtask

  function automatic bit hit_on(input int addr);
`ifdef BRICK_HIT_CLEAR_EN
    return addr >= 0;
`else
    return 1'b0;
`endif
  endfunction

  typedef struct {
    int px, py;
    int a1, c1, a2, c2;
    bit pc;
    int ex, ey;
    bit eh, ev, elost;
    int eha;
  } vec_t;

  vec_t tbl [10];

  initial begin
    bit lost, hv;
    int ha, pulses;
    int px, py;

    //           px   py   a1  c1  a2  c2  pc  ex   ey   eh ev lost eha
    tbl[0] = '{70,  110, -1, 0, -1, 0, 0,  79, 106, 1, 0, 0, -1};
    tbl[1] = '{70,  60,  3,  1, -1, 0, 0,  79, 58,  1, 1, 0, 3};
    tbl[2] = '{70,  60,  2,  3, 5,  1, 0,  77, 58,  0, 1, 0, 2};
    tbl[3] = '{70,  60,  0,  2, -1, 0, 0,  77, 56,  0, 0, 0, 0};
    tbl[4] = '{70,  60,  19, 1, -1, 0, 0,  79, 58,  1, 1, 0, 19};
    tbl[5] = '{149, 60,  -1, 0, -1, 0, 0,  156, 56, 0, 0, 0, -1};
    tbl[6] = '{70,  3,   -1, 0, -1, 0, 0,  79, 1,   1, 1, 0, -1};
    tbl[7] = '{70,  120, 0,  1, -1, 0, 0,  78, 117, 1, 0, 1, 0};
    tbl[8] = '{70,  120, 0,  1, -1, 0, 1,  79, 116, 1, 0, 0, 0};
    tbl[9] = '{70,  60,  -1, 0, -1, 0, 1,  79, 56,  1, 0, 0, -1};

    clear_codes();
    for (int i = 0; i < 10; i++) begin
      do_reset();
      clear_codes();
      if (tbl[i].a1 >= 0) mem_codes[tbl[i].a1] = 2'(tbl[i].c1);
      if (tbl[i].a2 >= 0) mem_codes[tbl[i].a2] = 2'(tbl[i].c2);
      launch_ball(tbl[i].px, tbl[i].py);
      run_frame(tbl[i].px + 8, tbl[i].py - 3, tbl[i].pc, tbl[i].elost, hit_on(tbl[i].eha),
                tbl[i].eha, 1'b0);
      chk("tbl_x", 32'(ball_x), tbl[i].ex);
      chk("tbl_y", 32'(ball_y), tbl[i].ey);
      chk("tbl_h", 32'(h_dir), 32'(tbl[i].eh));
      chk("tbl_v", 32'(v_dir), 32'(tbl[i].ev));
    end

    // Right wall reached moving down-right: (155,48) -> (156,49) -> (157,50) -> (156,51).
    do_reset();
    clear_codes();
    mem_codes[0] = 2'b01;
    launch_ball(147, 51);
    run_frame(155, 48, 1'b0, 1'b0, hit_on(0), 0, 1'b0);
    clear_codes();
    run_frame(156, 49, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    chk("wall_pre_x", 32'(ball_x), 157);
    chk("wall_pre_y", 32'(ball_y), 50);
    chk("wall_pre_v", 32'(v_dir), 1);
    run_frame(157, 50, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    chk("wall_x", 32'(ball_x), 156);
    chk("wall_y", 32'(ball_y), 51);
    chk("wall_h", 32'(h_dir), 0);

    // Reset in the middle of a scan after a hit has already been latched.
    do_reset();
    clear_codes();
    mem_codes[5] = 2'b01;
    launch_ball(70, 60);
    frame_tick = 1'b1;
    next_cycle();
    frame_tick = 1'b0;
    for (int s = 0; s < 10; s++) next_cycle();
    #1;
    chk("abort_addr", 32'(bus.brick_addr), 10);
    reset = 1'b1;
    next_cycle();
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_en", 32'(bus.enable_brick_detector), 0);
    chk("abort_x", 32'(ball_x), 78);
    reset = 1'b0;
    pulses = 0;
    for (int c = 0; c < N + 6; c++) begin
      next_cycle();
      #1;
      if (bus.brick_hit || ball_lost || busy) pulses++;
    end
    chk("abort_no_pulse", 32'(pulses), 0);

    // Randomized play against the frame-level model.
    do_reset();
    clear_codes();
    launch_ball(int'($urandom_range(0, 149)), int'($urandom_range(3, 120)));
    for (int f = 0; f < 200; f++) begin
      int pre_x, pre_y;
      bit pc;
      for (int a = 0; a < N; a++)
        mem_codes[a] = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      pc = ($urandom_range(0, 3) == 0);
      pre_x = m_x;
      pre_y = m_y;
      model_frame(pc, lost, hv, ha);
      run_frame(pre_x, pre_y, pc, lost, hv, ha, 1'b1);
      if (lost) begin
        chk("rnd_serve_x", 32'(ball_x), 32'(paddle_x) + 8);
        chk("rnd_serve_h", 32'(h_dir), 1);
        px = int'($urandom_range(0, 149));
        py = int'($urandom_range(3, 120));
        launch_ball(px, py);
      end else begin
        chk("rnd_x", 32'(ball_x), m_x);
        chk("rnd_y", 32'(ball_y), m_y);
        chk("rnd_h", 32'(h_dir), 32'(m_h));
        chk("rnd_v", 32'(v_dir), 32'(m_v));
        chk("rnd_nowrap_x", 32'(ball_x <= 8'(W - 3)), 1);
        chk("rnd_nowrap_y", 32'(ball_y <= 7'(H - 3)), 1);
        for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
          next_cycle();
          #1;
          chk("rnd_idle_busy", 32'(busy), 0);
          chk("rnd_idle_x", 32'(ball_x), m_x);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
